// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive blocks.
package uart_pkg;

   localparam int UART_DATA_BITS        = 8;
   localparam int UART_DEF_CLKS_PER_BIT = 16;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } uart_tx_state_t;

   // Parity bit that makes the frame even (odd=0) or odd (odd=1).
   function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx8_if.sv
// CPU-side transmit handshake plus the serial line of the UART transmitter.
interface uart_tx8_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] tx_data;
   logic                      tx_start;
   logic                      tx_ready;
   logic                      tx_done;
   logic                      tx;

   modport master (output tx_data, output tx_start, input tx_ready, input tx_done, input tx);
   modport slave  (input tx_data, input tx_start, output tx_ready, output tx_done, output tx);
endinterface

// File: rtl/uart_baud_cnt.sv
// Modulo-CLKS_PER_BIT bit-timing counter; bit_end marks the last cycle of a bit.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic bit_end
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign bit_end = (cnt_q == CNT_LAST) && !clr;

   // Next count: hold at zero while cleared, wrap after the last cycle of a bit.
   always_comb begin
      cnt_d = cnt_q;
      if (clr || bit_end) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx8.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
module uart_tx8
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic      clk,
   input  logic      rst,
   uart_tx8_if.slave bus
);

   uart_tx_state_t            state_q, state_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [2:0]                idx_q, idx_d;
   logic                      par_q, par_d;
   logic                      tx_q, tx_d;
   logic                      ready_q, ready_d;
   logic                      done_q, done_d;
   logic                      bit_end;
   logic                      baud_clr;
   logic                      accept;

   // The counter idles at zero so the start bit gets a full bit period.
   assign baud_clr = (state_q == TX_IDLE);
   assign accept   = bus.tx_start && ready_q;

   uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk     (clk),
      .rst     (rst),
      .clr     (baud_clr),
      .bit_end (bit_end)
   );

   // Next-state, data path and registered-output values.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      par_d   = par_q;
      done_d  = 1'b0;
      case (state_q)
         TX_IDLE: begin
            if (accept) begin
               state_d = TX_START;
               shift_d = bus.tx_data;
               par_d   = parity_bit(bus.tx_data, PARITY_ODD != 0);
               idx_d   = 3'd0;
            end else begin
               state_d = TX_IDLE;
            end
         end
         TX_START: begin
            if (bit_end) begin
               state_d = TX_DATA;
            end else begin
               state_d = TX_START;
            end
         end
         TX_DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
               if (idx_q == 3'd7) begin
                  idx_d   = 3'd0;
                  state_d = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
               end else begin
                  idx_d   = idx_q + 3'd1;
               end
            end else begin
               state_d = TX_DATA;
            end
         end
         TX_PARITY: begin
            if (bit_end) begin
               state_d = TX_STOP;
            end else begin
               state_d = TX_PARITY;
            end
         end
         TX_STOP: begin
            if (bit_end) begin
               state_d = TX_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = TX_STOP;
            end
         end
         default: begin
            state_d = TX_IDLE;
         end
      endcase

      // Line level follows the state being entered so tx changes on the transition edge.
      case (state_d)
         TX_IDLE:   tx_d = 1'b1;
         TX_START:  tx_d = 1'b0;
         TX_DATA:   tx_d = shift_d[0];
         TX_PARITY: tx_d = par_d;
         TX_STOP:   tx_d = 1'b1;
         default:   tx_d = 1'b1;
      endcase
      ready_d = (state_d == TX_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= TX_IDLE;
         shift_q <= 8'h00;
         idx_q   <= 3'd0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   assign bus.tx       = tx_q;
   assign bus.tx_ready = ready_q;
   assign bus.tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx8.sv
// Self-checking bench for uart_tx8: four configurations checked against a frame-level model.
module tb_uart_tx8;
   import uart_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx8_if if0 ();
   uart_tx8_if if1 ();
   uart_tx8_if if2 ();
   uart_tx8_if if3 ();

   logic [7:0] data_r  [4];
   logic       start_r [4];
   logic       tx_m    [4];
   logic       rdy_m   [4];
   logic       done_m  [4];

   assign if0.tx_data = data_r[0];  assign if0.tx_start = start_r[0];
   assign if1.tx_data = data_r[1];  assign if1.tx_start = start_r[1];
   assign if2.tx_data = data_r[2];  assign if2.tx_start = start_r[2];
   assign if3.tx_data = data_r[3];  assign if3.tx_start = start_r[3];
   assign tx_m[0] = if0.tx;  assign rdy_m[0] = if0.tx_ready;  assign done_m[0] = if0.tx_done;
   assign tx_m[1] = if1.tx;  assign rdy_m[1] = if1.tx_ready;  assign done_m[1] = if1.tx_done;
   assign tx_m[2] = if2.tx;  assign rdy_m[2] = if2.tx_ready;  assign done_m[2] = if2.tx_done;
   assign tx_m[3] = if3.tx;  assign rdy_m[3] = if3.tx_ready;  assign done_m[3] = if3.tx_done;

   uart_tx8 #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   uart_tx8 #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   uart_tx8 #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
   uart_tx8 #(.CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

   function automatic int cpb_of(input int d);
      return (d == 3) ? 2 : 4;
   endfunction
   function automatic int pe_of(input int d);
      return (d == 1 || d == 2) ? 1 : 0;
   endfunction
   function automatic int po_of(input int d);
      return (d == 2) ? 1 : 0;
   endfunction

   // Expected line level for bit slot j of a frame carrying byte b.
   function automatic logic exp_bit(input logic [7:0] b, input int pe, input int po, input int j);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      if (j == 0) return 1'b0;
      if (j <= 8) return b[j-1];
      if (pe != 0 && j == 9) return ((ones + po) % 2) == 1;
      return 1'b1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input int d, input string name);
      n_checks++;
      if (tx_m[d] !== 1'b1 || rdy_m[d] !== 1'b1 || done_m[d] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s d%0d tx/ready/done got %b%b%b want 110", name, d, tx_m[d], rdy_m[d], done_m[d]);
      end
   endtask

   task automatic launch(input int d, input logic [7:0] b);
      n_checks++;
      if (rdy_m[d] !== 1'b1) begin
         n_fail++;
         $display("FAIL launch_ready d%0d got %b want 1", d, rdy_m[d]);
      end
      data_r[d]  = b;
      start_r[d] = 1'b1;
   endtask

   // Next edge accepts byte b; every cycle of the frame and the done cycle are checked.
   task automatic check_frame(input int d, input logic [7:0] b, input int hold,
                              input logic [7:0] after_data, input int pulse_at, input string name);
      int cpb, pe, po, len;
      logic e;
      cpb = cpb_of(d);
      pe  = pe_of(d);
      po  = po_of(d);
      len = (10 + pe) * cpb;
      tick();
      start_r[d] = (hold != 0);
      data_r[d]  = after_data;
      for (int k = 0; k < len; k++) begin
         e = exp_bit(b, pe, po, k / cpb);
         n_checks++;
         if (tx_m[d] !== e) begin
            n_fail++;
            $display("FAIL %s_tx d%0d cycle %0d got %b want %b", name, d, k, tx_m[d], e);
         end
         n_checks++;
         if (rdy_m[d] !== 1'b0 || done_m[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy d%0d cycle %0d ready/done got %b%b want 00", name, d, k, rdy_m[d], done_m[d]);
         end
         if (pulse_at >= 0 && k == pulse_at) begin
            start_r[d] = 1'b1;
            data_r[d]  = 8'hFF;
         end else if (pulse_at >= 0 && k == pulse_at + 1) begin
            start_r[d] = 1'b0;
            data_r[d]  = after_data;
         end
         tick();
      end
      n_checks++;
      if (done_m[d] !== 1'b1 || rdy_m[d] !== 1'b1 || tx_m[d] !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_done d%0d at %0d done/ready/tx got %b%b%b want 111", name, d, len, done_m[d], rdy_m[d], tx_m[d]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      for (int d = 0; d < 4; d++) check_idle(d, "reset_init");
      tick();
      tick();
      rst = 1'b0;
      launch(0, 8'h5A);
      tick();
      start_r[0] = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      check_idle(0, "reset_midframe");
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < 50; k++) begin
         tick();
         check_idle(0, "reset_after");
      end
   endtask

   task automatic test_basic();
      launch(0, 8'hA5);
      check_frame(0, 8'hA5, 0, 8'h5A, -1, "a5");
   endtask

   task automatic test_parity();
      launch(1, 8'h07);
      check_frame(1, 8'h07, 0, 8'h00, -1, "par_even");
      launch(2, 8'h07);
      check_frame(2, 8'h07, 0, 8'h00, -1, "par_odd");
   endtask

   task automatic test_ignore();
      launch(0, 8'h3C);
      check_frame(0, 8'h3C, 0, 8'h3C, 10, "ignore");
      tick();
      check_idle(0, "ignore_noqueue");
   endtask

   task automatic test_back_to_back();
      launch(0, 8'h01);
      check_frame(0, 8'h01, 1, 8'h80, -1, "b2b_first");
      check_frame(0, 8'h80, 0, 8'h00, -1, "b2b_second");
      tick();
      check_idle(0, "b2b_end");
   endtask

   task automatic test_cpb2();
      launch(3, 8'h00);
      check_frame(3, 8'h00, 0, 8'hFF, -1, "cpb2");
   endtask

   task automatic test_random();
      int d;
      logic [7:0] b;
      for (int i = 0; i < 16; i++) begin
         d = int'($urandom_range(0, 3));
         b = 8'($urandom);
         repeat ($urandom_range(0, 3)) tick();
         launch(d, b);
         check_frame(d, b, 0, 8'($urandom), -1, "rand");
      end
   endtask

   initial begin
      for (int d = 0; d < 4; d++) begin
         data_r[d]  = 8'h00;
         start_r[d] = 1'b0;
      end
      #1;
      test_reset();
      test_basic();
      test_parity();
      test_ignore();
      test_back_to_back();
      test_cpb2();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
